// File: rtl/merge_2_input.sv
// Two-input depth-concat stage: emits every input-1 map of a frame, then every input-2 map.
// Input-2 words that arrive early are held in an N2-deep FIFO until their phase comes.
module merge_2_input #(
  parameter int unsigned D          = 299,
  parameter int unsigned IN1_CH     = 1,
  parameter int unsigned IN2_CH     = 1,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in_1,
  input  logic [DATA_WIDTH-1:0] pxl_in_1,
  input  logic                  valid_in_2,
  input  logic [DATA_WIDTH-1:0] pxl_in_2,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out
);

  localparam int unsigned N1     = IN1_CH * D * D;
  localparam int unsigned N2     = IN2_CH * D * D;
  localparam int unsigned CNT1_W = $clog2(N1 + 1);
  localparam int unsigned CNT2_W = $clog2(N2 + 1);
  localparam int unsigned PTR_W  = (N2 > 1) ? $clog2(N2) : 1;
  localparam int unsigned OCC_W  = $clog2(N2 + 1);

  localparam logic [0:0] PH1 = 1'b0;
  localparam logic [0:0] PH2 = 1'b1;

  logic [0:0]            state, state_nxt;
  logic [CNT1_W-1:0]     cnt1, cnt1_nxt;
  logic [CNT2_W-1:0]     cnt2, cnt2_nxt;
  logic [DATA_WIDTH-1:0] pxl_nxt;
  logic                  valid_nxt;

  logic [DATA_WIDTH-1:0] mem [N2];
  logic [PTR_W-1:0]      wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
  logic [OCC_W-1:0]      occ, occ_nxt;
  logic                  push, pop;

  // A push into a full buffer is dropped, judged on occupancy before this edge.
  assign push = valid_in_2 && (occ != OCC_W'(N2));

  // Phase sequencing and output selection.
  always_comb begin
    state_nxt = state;
    cnt1_nxt  = cnt1;
    cnt2_nxt  = cnt2;
    valid_nxt = 1'b0;
    pxl_nxt   = pxl_out;
    pop       = 1'b0;
    case (state)
      PH1: begin
        if (valid_in_1) begin
          valid_nxt = 1'b1;
          pxl_nxt   = pxl_in_1;
          if (cnt1 == CNT1_W'(N1 - 1)) begin
            cnt1_nxt  = '0;
            state_nxt = PH2;
          end else begin
            cnt1_nxt = cnt1 + CNT1_W'(1);
          end
        end
      end
      PH2: begin
        if (occ != '0) begin
          pop       = 1'b1;
          valid_nxt = 1'b1;
          pxl_nxt   = mem[rd_ptr];
          if (cnt2 == CNT2_W'(N2 - 1)) begin
            cnt2_nxt  = '0;
            state_nxt = PH1;
          end else begin
            cnt2_nxt = cnt2 + CNT2_W'(1);
          end
        end
      end
    endcase
  end

  // Circular buffer pointer and occupancy update.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    occ_nxt    = occ;
    if (push) begin
      wr_ptr_nxt = (wr_ptr == PTR_W'(N2 - 1)) ? '0 : wr_ptr + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_nxt = (rd_ptr == PTR_W'(N2 - 1)) ? '0 : rd_ptr + PTR_W'(1);
    end
    if (push && !pop) begin
      occ_nxt = occ + OCC_W'(1);
    end else if (pop && !push) begin
      occ_nxt = occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= PH1;
      cnt1      <= '0;
      cnt2      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      valid_out <= 1'b0;
      pxl_out   <= '0;
    end else begin
      state     <= state_nxt;
      cnt1      <= cnt1_nxt;
      cnt2      <= cnt2_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      occ       <= occ_nxt;
      valid_out <= valid_nxt;
      pxl_out   <= pxl_nxt;
    end
  end

  // Storage array carries no reset; occupancy alone defines what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pxl_in_2;
    end
  end

endmodule

// File: tb/tb_merge_2_input.sv
// Directed + random bench for merge_2_input (D=3, one map per input, so 9 pixels per phase).
// A queue-based model of the concat predicts every output cycle.
module tb_merge_2_input;

  localparam int unsigned D      = 3;
  localparam int unsigned IN1_CH = 1;
  localparam int unsigned IN2_CH = 1;
  localparam int unsigned DW     = 32;
  localparam int          N1     = IN1_CH * D * D;
  localparam int          N2     = IN2_CH * D * D;

  logic          clk;
  logic          reset;
  logic          valid_in_1, valid_in_2, valid_out;
  logic [DW-1:0] pxl_in_1, pxl_in_2, pxl_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: which stream is being emitted and how many of its pixels went out.
  int            m_phase;
  int            m_sent;
  logic [DW-1:0] m_buf[$];
  bit            exp_v;
  logic [DW-1:0] exp_p;

  logic [DW-1:0] obs[$];
  int            obs_cyc[$];
  logic [DW-1:0] want[$];

  merge_2_input #(D, IN1_CH, IN2_CH, DW) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in_1 (valid_in_1),
    .pxl_in_1   (pxl_in_1),
    .valid_in_2 (valid_in_2),
    .pxl_in_2   (pxl_in_2),
    .pxl_out    (pxl_out),
    .valid_out  (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed still running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [DW-1:0] o, input logic [DW-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    m_phase = 1;
    m_sent  = 0;
    m_buf.delete();
    exp_v   = 1'b0;
    exp_p   = '0;
  endtask

  // One clock edge of the concat: phase 1 forwards input 1, phase 2 drains the buffer.
  task automatic model_edge(input bit v1, input logic [DW-1:0] p1,
                            input bit v2, input logic [DW-1:0] p2);
    bit was_full;
    was_full = (m_buf.size() >= N2);
    exp_v = 1'b0;
    if (m_phase == 1) begin
      if (v1) begin
        exp_v = 1'b1;
        exp_p = p1;
        m_sent++;
        if (m_sent == N1) begin m_phase = 2; m_sent = 0; end
      end
    end else if (m_buf.size() > 0) begin
      exp_v = 1'b1;
      exp_p = m_buf.pop_front();
      m_sent++;
      if (m_sent == N2) begin m_phase = 1; m_sent = 0; end
    end
    if (v2 && !was_full) m_buf.push_back(p2);
  endtask

  task automatic step(input bit v1, input logic [DW-1:0] p1,
                      input bit v2, input logic [DW-1:0] p2);
    valid_in_1 = v1;
    pxl_in_1   = p1;
    valid_in_2 = v2;
    pxl_in_2   = p2;
    @(posedge clk);
    if (!reset) model_reset();
    else        model_edge(v1, p1, v2, p2);
    cyc++;
    #1;
    chk("valid_out", DW'(valid_out), DW'(exp_v));
    chk("pxl_out", pxl_out, exp_p);
    if (valid_out === 1'b1) begin
      obs.push_back(pxl_out);
      obs_cyc.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, DW'($urandom), 1'b0, DW'($urandom));
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock.
  task automatic reset_pulse(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    chk({tag, "_valid_async"}, DW'(valid_out), DW'(0));
    chk({tag, "_pxl_async"}, pxl_out, DW'(0));
    step(1'b1, DW'($urandom), 1'b1, DW'($urandom));
    reset = 1'b1;
  endtask

  task automatic check_list(input string tag);
    chk({tag, "_count"}, DW'(obs.size()), DW'(want.size()));
    for (int i = 0; i < want.size() && i < obs.size(); i++) chk({tag, "_data"}, obs[i], want[i]);
  endtask

  task automatic clear_obs();
    obs.delete();
    obs_cyc.delete();
    want.delete();
  endtask

  initial begin
    valid_in_1 = 1'b0; valid_in_2 = 1'b0;
    pxl_in_1   = '0;   pxl_in_2   = '0;
    reset      = 1'b0;
    model_reset();
    #1;
    chk("reset_valid_t0", DW'(valid_out), DW'(0));
    chk("reset_pxl_t0", pxl_out, DW'(0));

    // Reset held with random traffic
    for (int i = 0; i < 3; i++) begin
      step(1'b1, DW'($urandom), 1'b1, DW'($urandom));
      chk("reset_hold_valid", DW'(valid_out), DW'(0));
      chk("reset_hold_pxl", pxl_out, DW'(0));
    end
    reset = 1'b1;
    step(1'b1, DW'('hA0), 1'b0, '0);
    chk("first_after_reset", pxl_out, DW'('hA0));
    reset_pulse("realign0");

    // Sequential frames: input 2 arrives only after input 1 finished
    clear_obs();
    for (int i = 0; i < 9; i++) step(1'b1, DW'('h100 + i), 1'b0, '0);
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, DW'('h200 + i));
    idle(2);
    for (int i = 0; i < 9; i++) want.push_back(DW'('h100 + i));
    for (int i = 0; i < 9; i++) want.push_back(DW'('h200 + i));
    check_list("seq");

    // Overlapped arrival: buffered input 2 drains back to back
    clear_obs();
    for (int i = 0; i < 9; i++) step(1'b1, DW'('h100 + i), 1'b1, DW'('h200 + i));
    idle(10);
    for (int i = 0; i < 9; i++) want.push_back(DW'('h100 + i));
    for (int i = 0; i < 9; i++) want.push_back(DW'('h200 + i));
    check_list("overlap");
    if (obs_cyc.size() == 18) chk("overlap_no_gap", DW'(obs_cyc[17] - obs_cyc[0]), DW'(17));
    else chk("overlap_beats", DW'(obs_cyc.size()), DW'(18));

    // Input 1 ignored during phase 2
    clear_obs();
    for (int i = 0; i < 9; i++) step(1'b1, DW'('h110 + i), 1'b0, '0);
    for (int i = 0; i < 9; i++) step(1'b1, DW'('hDEAD), 1'b1, DW'('h300 + i));
    step(1'b1, DW'('hDEAD), 1'b0, '0);
    step(1'b1, DW'('h400), 1'b0, '0);
    begin
      int dead_seen;
      dead_seen = 0;
      foreach (obs[i]) if (obs[i] == DW'('hDEAD)) dead_seen++;
      chk("ign_no_dead", DW'(dead_seen), DW'(0));
    end
    chk("ign_count", DW'(obs.size()), DW'(19));
    if (obs.size() >= 2) begin
      chk("ign_last_in2", obs[obs.size() - 2], DW'('h308));
      chk("ign_back_ph1", obs[obs.size() - 1], DW'('h400));
    end
    reset_pulse("realign1");

    // Overflow: 12 pushes during phase 1, only 9 survive
    clear_obs();
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, DW'('h500 + i));
    for (int i = 0; i < 9; i++) step(1'b1, DW'('h600 + i), 1'b0, '0);
    idle(12);
    for (int i = 0; i < 9; i++) want.push_back(DW'('h600 + i));
    for (int i = 0; i < 9; i++) want.push_back(DW'('h500 + i));
    check_list("ovf");
    step(1'b1, DW'('h610), 1'b0, '0);
    chk("ovf_back_ph1", pxl_out, DW'('h610));
    reset_pulse("realign2");

    // Asynchronous reset in the middle of phase 2
    clear_obs();
    for (int i = 0; i < 9; i++) step(1'b1, DW'('h700 + i), 1'b1, DW'('h720 + i));
    idle(4);
    chk("ph2_partial_count", DW'(obs.size()), DW'(13));
    reset_pulse("midph2");
    step(1'b0, '0, 1'b0, '0);
    clear_obs();
    for (int i = 0; i < 9; i++) step(1'b1, DW'('h800 + i), 1'b0, '0);
    idle(12);
    for (int i = 0; i < 9; i++) want.push_back(DW'('h800 + i));
    check_list("post_reset");

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), DW'($urandom),
           1'($urandom_range(0, 1)), DW'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
